// File: rtl/ebus_io_responder_pkg.sv
// Shared types and status/CONO/CONI bit positions for the EBUS I/O responder.
// Bit numbers follow the EBUS [0:35] convention: bit 35 is the least significant.
package ebus_io_responder_pkg;

    typedef struct packed {
        logic        driving;
        logic [0:35] data;
    } tEBUSdriver;

    typedef enum logic [2:0] {
        FN_CONO    = 3'd0,
        FN_CONI    = 3'd1,
        FN_DATAO   = 3'd2,
        FN_DATAI   = 3'd3,
        FN_PISERVE = 3'd4
    } tEbusFunc;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACT,
        ST_XFER
    } tRespState;

    localparam int PIA_HI        = 33;
    localparam int PIA_LO        = 35;
    localparam int RXIE_BIT      = 32;
    localparam int TXIE_BIT      = 31;
    localparam int CLR_FLAGS_BIT = 30;
    localparam int CLR_FIFOS_BIT = 29;
    localparam int RXNE_BIT      = 30;
    localparam int TXNF_BIT      = 29;
    localparam int RXOVF_BIT     = 28;
    localparam int TXOVR_BIT     = 27;

    // Functions that put a word back onto the EBUS data lines.
    function automatic logic isReadFunc(input logic [2:0] fn);
        return (fn == FN_CONI) || (fn == FN_DATAI) || (fn == FN_PISERVE);
    endfunction

endpackage

// File: rtl/ebus_io_responder_if.sv
// EBUS-side and device-side signals of one I/O responder, grouped for port use.
interface ebus_io_responder_if;
    import ebus_io_responder_pkg::*;

    logic [0:6]  ebus_cs;
    logic [0:2]  ebus_func;
    logic        ebus_demand;
    logic [0:35] ebus_data_in;
    tEBUSdriver  EBUSdriver;
    logic        ebus_xfer;
    logic [0:7]  ebus_pi;
    logic [0:35] dev_tx_data;
    logic        dev_tx_valid;
    logic        dev_tx_ready;
    logic [0:35] dev_rx_data;
    logic        dev_rx_valid;
    logic        dev_rx_ready;

    modport slave (
        input  ebus_cs, ebus_func, ebus_demand, ebus_data_in,
               dev_tx_ready, dev_rx_data, dev_rx_valid,
        output EBUSdriver, ebus_xfer, ebus_pi,
               dev_tx_data, dev_tx_valid, dev_rx_ready
    );

    modport master (
        output ebus_cs, ebus_func, ebus_demand, ebus_data_in,
               dev_tx_ready, dev_rx_data, dev_rx_valid,
        input  EBUSdriver, ebus_xfer, ebus_pi,
               dev_tx_data, dev_tx_valid, dev_rx_ready
    );

endinterface

// File: rtl/ebus_io_responder_fifo.sv
// Power-of-two word FIFO used for both the TX and RX paths of the responder.
// A pop in the same cycle frees a slot, so push-while-full is accepted then.
module ebus_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        i_push,
    input  logic [0:35] i_push_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic        o_full,
    output logic        o_empty,
    output logic [0:35] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [0:35]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // Flush wins over any concurrent push or pop; that word is simply lost.
    always_ff @(posedge clk) begin
        if (!reset_l || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ebus_io_responder.sv
// Device end of the EBUS CONO/CONI/DATAO/DATAI/PI-serve handshake with a
// status register, TX/RX word FIFOs and a PI request on the assigned channel.
module ebus_io_responder
    import ebus_io_responder_pkg::*;
#(
    parameter logic [0:6]  DEVICE_CS  = 7'o20,
    parameter logic [0:35] VECTOR     = 36'o0,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                reset_l,
    ebus_io_responder_if.slave bus
);

    tRespState   r_state;
    logic [2:0]  r_func;
    logic [0:35] r_rdata;
    logic [0:35] r_drv_data;
    logic        r_drv;
    logic        r_xfer;

    logic [2:0]  r_pia;
    logic        r_rxie;
    logic        r_txie;
    logic        r_rxovf;
    logic        r_txovr;

    logic        w_act, w_cono, w_datao, w_datai, w_flush;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_pop, w_rx_pop;
    logic [0:35] w_tx_head, w_rx_head;
    logic [0:35] w_coni, w_read_word;
    logic [0:7]  w_pi;

    assign w_act    = (r_state == ST_ACT);
    assign w_cono   = w_act && (r_func == FN_CONO);
    assign w_datao  = w_act && (r_func == FN_DATAO);
    assign w_datai  = w_act && (r_func == FN_DATAI);
    assign w_flush  = w_cono && bus.ebus_data_in[CLR_FIFOS_BIT];
    assign w_tx_pop = bus.dev_tx_ready && !w_tx_empty;
    assign w_rx_pop = w_datai && !w_rx_empty;

    ebus_word_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .reset_l     (reset_l),
        .i_push      (w_datao),
        .i_push_data (bus.ebus_data_in),
        .i_pop       (w_tx_pop),
        .i_flush     (w_flush),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_head      (w_tx_head)
    );

    ebus_word_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .reset_l     (reset_l),
        .i_push      (bus.dev_rx_valid),
        .i_push_data (bus.dev_rx_data),
        .i_pop       (w_rx_pop),
        .i_flush     (w_flush),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_head      (w_rx_head)
    );

    always_comb begin
        w_coni                   = '0;
        w_coni[PIA_HI:PIA_LO]    = r_pia;
        w_coni[RXIE_BIT]         = r_rxie;
        w_coni[TXIE_BIT]         = r_txie;
        w_coni[RXNE_BIT]         = !w_rx_empty;
        w_coni[TXNF_BIT]         = !w_tx_full;
        w_coni[RXOVF_BIT]        = r_rxovf;
        w_coni[TXOVR_BIT]        = r_txovr;
    end

    always_comb begin
        w_read_word = '0;
        case (r_func)
            FN_CONI:    w_read_word = w_coni;
            FN_DATAI:   w_read_word = w_rx_head;
            FN_PISERVE: w_read_word = VECTOR;
            default:    w_read_word = '0;
        endcase
    end

    always_comb begin
        w_pi = '0;
        if ((r_pia != 3'd0) && ((r_rxie && !w_rx_empty) || (r_txie && w_tx_empty)))
            w_pi[r_pia] = 1'b1;
    end

    // Overflow flags are set after the CONO clear so a same-cycle overflow is kept.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_pia   <= '0;
            r_rxie  <= 1'b0;
            r_txie  <= 1'b0;
            r_rxovf <= 1'b0;
            r_txovr <= 1'b0;
        end else begin
            if (w_cono) begin
                r_pia  <= bus.ebus_data_in[PIA_HI:PIA_LO];
                r_rxie <= bus.ebus_data_in[RXIE_BIT];
                r_txie <= bus.ebus_data_in[TXIE_BIT];
                if (bus.ebus_data_in[CLR_FLAGS_BIT]) begin
                    r_rxovf <= 1'b0;
                    r_txovr <= 1'b0;
                end
            end
            if (w_datao && w_tx_full && !w_tx_pop)
                r_txovr <= 1'b1;
            if (bus.dev_rx_valid && w_rx_full && !w_rx_pop && !w_flush)
                r_rxovf <= 1'b1;
        end
    end

    // Bus outputs are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state    <= ST_IDLE;
            r_func     <= '0;
            r_rdata    <= '0;
            r_xfer     <= 1'b0;
            r_drv      <= 1'b0;
            r_drv_data <= '0;
        end else begin
            r_xfer     <= (r_state == ST_XFER);
            r_drv      <= (r_state == ST_XFER) && isReadFunc(r_func);
            r_drv_data <= ((r_state == ST_XFER) && isReadFunc(r_func)) ? r_rdata : '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ebus_demand && (bus.ebus_cs == DEVICE_CS)) begin
                        r_state <= ST_ACT;
                        r_func  <= bus.ebus_func;
                    end
                end
                ST_ACT: begin
                    r_rdata <= w_read_word;
                    r_state <= bus.ebus_demand ? ST_XFER : ST_IDLE;
                end
                ST_XFER: begin
                    if (!bus.ebus_demand)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ebus_xfer    = r_xfer;
    assign bus.EBUSdriver   = '{driving: r_drv, data: r_drv_data};
    assign bus.ebus_pi      = w_pi;
    assign bus.dev_tx_data  = w_tx_head;
    assign bus.dev_tx_valid = !w_tx_empty;
    assign bus.dev_rx_ready = 1'b1;

endmodule

// File: tb/tb_ebus_io_responder.sv
// Directed bench for ebus_io_responder: one task per scenario, inline comparisons.
module tb_ebus_io_responder;
    import ebus_io_responder_pkg::*;

    localparam logic [0:6]  DEV_CS = 7'o20;
    localparam logic [0:35] VEC    = 36'o123456701234;

    logic clk;
    logic reset_l;
    int   total;
    int   bad;

    ebus_io_responder_if bus ();

    ebus_io_responder #(
        .DEVICE_CS  (DEV_CS),
        .VECTOR     (VEC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full demand/xfer handshake; leaves the bus idle with demand low.
    task automatic busOp(input logic [2:0] fn, input logic [0:35] data,
                         output logic [0:35] rword, output logic drv, output logic got);
        bus.ebus_cs      = DEV_CS;
        bus.ebus_func    = fn;
        bus.ebus_data_in = data;
        bus.ebus_demand  = 1'b1;
        got   = 1'b0;
        drv   = 1'b0;
        rword = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.ebus_xfer) begin
                got   = 1'b1;
                drv   = bus.EBUSdriver.driving;
                rword = bus.EBUSdriver.data;
            end
        end
        bus.ebus_demand = 1'b0;
        tick();
        tick();
    endtask

    task automatic devPush(input logic [0:35] data);
        bus.dev_rx_valid = 1'b1;
        bus.dev_rx_data  = data;
        tick();
        bus.dev_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_l          = 1'b0;
        bus.ebus_cs      = '0;
        bus.ebus_func    = '0;
        bus.ebus_demand  = 1'b0;
        bus.ebus_data_in = '0;
        bus.dev_tx_ready = 1'b0;
        bus.dev_rx_data  = '0;
        bus.dev_rx_valid = 1'b0;
        repeat (3) tick();
        total++; if (bus.ebus_xfer !== 1'b0) begin bad++; $display("[TB] FAIL reset_xfer got=%b exp=0", bus.ebus_xfer); end
        total++; if (bus.EBUSdriver !== '0) begin bad++; $display("[TB] FAIL reset_driver got=%o exp=0", bus.EBUSdriver); end
        total++; if (bus.ebus_pi !== 8'b0) begin bad++; $display("[TB] FAIL reset_pi got=%b exp=0", bus.ebus_pi); end
        total++; if (bus.dev_tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid got=%b exp=0", bus.dev_tx_valid); end
        total++; if (bus.dev_rx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_rx_ready got=%b exp=1", bus.dev_rx_ready); end
        reset_l = 1'b1;
        tick();
    endtask

    task automatic test_cono_coni();
        logic [0:35] w;
        logic        drv, got;
        bus.ebus_cs      = DEV_CS;
        bus.ebus_func    = 3'd0;
        bus.ebus_data_in = 36'o000000000144;
        bus.ebus_demand  = 1'b1;
        tick();
        total++; if (bus.ebus_xfer !== 1'b0) begin bad++; $display("[TB] FAIL cono_xfer_n got=%b exp=0", bus.ebus_xfer); end
        tick();
        total++; if (bus.ebus_xfer !== 1'b0) begin bad++; $display("[TB] FAIL cono_xfer_n1 got=%b exp=0", bus.ebus_xfer); end
        tick();
        total++; if (bus.ebus_xfer !== 1'b1) begin bad++; $display("[TB] FAIL cono_xfer_n2 got=%b exp=1", bus.ebus_xfer); end
        total++; if (bus.EBUSdriver.driving !== 1'b0) begin bad++; $display("[TB] FAIL cono_nodrive got=%b exp=0", bus.EBUSdriver.driving); end
        tick();
        tick();
        bus.ebus_demand = 1'b0;
        tick();
        total++; if (bus.ebus_xfer !== 1'b1) begin bad++; $display("[TB] FAIL cono_xfer_hold got=%b exp=1", bus.ebus_xfer); end
        tick();
        total++; if (bus.ebus_xfer !== 1'b0) begin bad++; $display("[TB] FAIL cono_xfer_fall got=%b exp=0", bus.ebus_xfer); end
        // PIA=4, RXIE/TXIE=0, TX not full (bit 29) -> 0o104
        busOp(3'd1, '0, w, drv, got);
        total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL coni_xfer got=%b exp=1", got); end
        total++; if (drv !== 1'b1) begin bad++; $display("[TB] FAIL coni_drive got=%b exp=1", drv); end
        total++; if (w !== 36'o000000000104) begin bad++; $display("[TB] FAIL coni_word got=%o exp=104", w); end
        total++; if (bus.ebus_pi !== 8'b0) begin bad++; $display("[TB] FAIL coni_pi got=%b exp=0", bus.ebus_pi); end
    endtask

    task automatic test_datao_overflow();
        logic [0:35] w;
        logic        drv, got;
        bus.dev_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busOp(3'd2, 36'o1001 + 36'(i), w, drv, got);
            total++; if (got !== 1'b1 || drv !== 1'b0) begin bad++; $display("[TB] FAIL datao_ack_%0d got=%b%b exp=10", i, got, drv); end
        end
        // PIA=4, TXOVR (bit 27), TX full -> 0o404
        busOp(3'd1, '0, w, drv, got);
        total++; if (w !== 36'o000000000404) begin bad++; $display("[TB] FAIL datao_coni got=%o exp=404", w); end
        bus.dev_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.dev_tx_valid !== 1'b1 || bus.dev_tx_data !== 36'o1001 + 36'(i)) begin
                bad++; $display("[TB] FAIL tx_drain_%0d got=%b/%o exp=1/%o", i, bus.dev_tx_valid, bus.dev_tx_data, 36'o1001 + 36'(i));
            end
            tick();
        end
        total++; if (bus.dev_tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL tx_drained got=%b exp=0", bus.dev_tx_valid); end
        bus.dev_tx_ready = 1'b0;
    endtask

    task automatic test_rx_pi();
        logic [0:35] w;
        logic        drv, got;
        // PIA=2, RXIE=1, clear flags, empty FIFOs
        busOp(3'd0, 36'o000000000152, w, drv, got);
        total++; if (bus.ebus_pi !== 8'b0) begin bad++; $display("[TB] FAIL rx_pi_idle got=%b exp=0", bus.ebus_pi); end
        devPush(36'o123);
        devPush(36'o456);
        total++; if (bus.ebus_pi !== 8'b00100000) begin bad++; $display("[TB] FAIL rx_pi_req got=%b exp=00100000", bus.ebus_pi); end
        busOp(3'd3, '0, w, drv, got);
        total++; if (w !== 36'o123 || drv !== 1'b1) begin bad++; $display("[TB] FAIL datai_1 got=%o/%b exp=123/1", w, drv); end
        busOp(3'd3, '0, w, drv, got);
        total++; if (w !== 36'o456 || drv !== 1'b1) begin bad++; $display("[TB] FAIL datai_2 got=%o/%b exp=456/1", w, drv); end
        total++; if (bus.ebus_pi !== 8'b0) begin bad++; $display("[TB] FAIL rx_pi_clear got=%b exp=0", bus.ebus_pi); end
        busOp(3'd3, '0, w, drv, got);
        total++; if (w !== 36'o0 || drv !== 1'b1 || got !== 1'b1) begin bad++; $display("[TB] FAIL datai_empty got=%o/%b/%b exp=0/1/1", w, drv, got); end
    endtask

    task automatic test_cs_mismatch();
        logic [0:35] w;
        logic        drv, got;
        logic        seen;
        bus.ebus_cs     = 7'o21;
        bus.ebus_func   = 3'd4;
        bus.ebus_demand = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.ebus_xfer || bus.EBUSdriver.driving) seen = 1'b1;
        end
        bus.ebus_demand = 1'b0;
        tick();
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL cs_ignored got=%b exp=0", seen); end
        // PIA=2, RXIE=1, TX not full, both FIFOs empty -> 0o112
        busOp(3'd1, '0, w, drv, got);
        total++; if (w !== 36'o000000000112) begin bad++; $display("[TB] FAIL cs_coni got=%o exp=112", w); end
        busOp(3'd4, '0, w, drv, got);
        total++; if (w !== VEC || drv !== 1'b1) begin bad++; $display("[TB] FAIL piserve got=%o/%b exp=%o/1", w, drv, VEC); end
        busOp(3'd5, 36'o777, w, drv, got);
        total++; if (got !== 1'b1 || drv !== 1'b0 || w !== 36'o0) begin bad++; $display("[TB] FAIL func5 got=%b%b/%o exp=10/0", got, drv, w); end
    endtask

    task automatic test_back_to_back();
        logic [0:35] w;
        logic        drv, got;
        busOp(3'd0, 36'o000000000152, w, drv, got);
        for (int i = 0; i < 4; i++) devPush(36'o11 + 36'(i));
        bus.ebus_cs     = DEV_CS;
        bus.ebus_func   = 3'd3;
        bus.ebus_demand = 1'b1;
        tick();
        bus.dev_rx_valid = 1'b1;
        bus.dev_rx_data  = 36'o15;
        tick();
        bus.dev_rx_valid = 1'b0;
        got = 1'b0;
        w   = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.ebus_xfer) begin
                got = 1'b1;
                w   = bus.EBUSdriver.data;
            end
        end
        bus.ebus_demand = 1'b0;
        tick();
        tick();
        total++; if (got !== 1'b1 || w !== 36'o11) begin bad++; $display("[TB] FAIL simul_datai got=%b/%o exp=1/11", got, w); end
        // RX non-empty, no RXOVF: PIA=2 | RXIE | RXNE | TXNF -> 0o152
        busOp(3'd1, '0, w, drv, got);
        total++; if (w !== 36'o000000000152) begin bad++; $display("[TB] FAIL simul_coni got=%o exp=152", w); end
        for (int i = 0; i < 4; i++) begin
            busOp(3'd3, '0, w, drv, got);
            total++; if (w !== 36'o12 + 36'(i)) begin bad++; $display("[TB] FAIL simul_drain_%0d got=%o exp=%o", i, w, 36'o12 + 36'(i)); end
        end
        busOp(3'd3, '0, w, drv, got);
        total++; if (w !== 36'o0) begin bad++; $display("[TB] FAIL simul_count got=%o exp=0", w); end
        for (int i = 0; i < 5; i++) devPush(36'o21 + 36'(i));
        busOp(3'd1, '0, w, drv, got);
        total++; if (w !== 36'o000000000352) begin bad++; $display("[TB] FAIL rxovf_coni got=%o exp=352", w); end
    endtask

    task automatic test_reset_midop();
        logic [0:35] w;
        logic        drv, got;
        bus.dev_tx_ready = 1'b0;
        bus.ebus_cs      = DEV_CS;
        bus.ebus_func    = 3'd2;
        bus.ebus_data_in = 36'o777;
        bus.ebus_demand  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.ebus_xfer) got = 1'b1;
        end
        total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL midop_xfer got=%b exp=1", got); end
        reset_l = 1'b0;
        tick();
        total++; if (bus.ebus_xfer !== 1'b0 || bus.EBUSdriver.driving !== 1'b0) begin bad++; $display("[TB] FAIL midop_abort got=%b%b exp=00", bus.ebus_xfer, bus.EBUSdriver.driving); end
        total++; if (bus.dev_tx_valid !== 1'b0 || bus.ebus_pi !== 8'b0) begin bad++; $display("[TB] FAIL midop_state got=%b/%b exp=0/0", bus.dev_tx_valid, bus.ebus_pi); end
        reset_l         = 1'b1;
        bus.ebus_demand = 1'b0;
        tick();
        busOp(3'd1, '0, w, drv, got);
        total++; if (w !== 36'o000000000100) begin bad++; $display("[TB] FAIL midop_coni got=%o exp=100", w); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cono_coni();
        test_datao_overflow();
        test_rx_pi();
        test_cs_mismatch();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
